input_conditioner: RTL
======================

// Module: input_conditioner
// PURPOSE
//  Input-side companion to the lab logic blocks: conditions raw board inputs
//  (switches/buttons) before they reach combinational logic and LEDs.
//  Per channel: 2-flop synchroniser, counter-based debounce FSM, clean level,
//  single-cycle rise/fall pulses and a press-toggled latch.
//  Sits between top-level pins and the logic modules; one clock domain.
// PARAMETERS
//  WIDTH            4       number of independent input channels
//  DEBOUNCE_CYCLES  500000  stable cycles required to accept a change (>=1)
//  CNT_W            19      counter width; 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  raw_in      in   WIDTH  unsynchronised switch/button inputs
//  level_out   out  WIDTH  debounced level
//  rise_pulse  out  WIDTH  1-cycle pulse when level_out goes 0->1
//  fall_pulse  out  WIDTH  1-cycle pulse when level_out goes 1->0
//  toggle_out  out  WIDTH  inverts on every rise_pulse
// BEHAVIOUR
//  - Reset (rst_n=0, async): sync flops, counters, level_out, rise_pulse,
//    fall_pulse, toggle_out all 0; every FSM in STABLE_LO. Release is used
//    synchronously; first active edge is the one after rst_n rises.
//  - Sync: sync1<=raw_in[i], sync2<=sync1; FSM sees sync2 only.
//  - FSM per channel, states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO:
//    STABLE_LO: sync2=1 -> WAIT_HI, cnt<=0.
//    WAIT_HI: sync2=0 -> STABLE_LO, cnt<=0 (bounce rejected, no pulse);
//      sync2=1 & cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, level_out<=1,
//      rise_pulse<=1, toggle_out<=~toggle_out; else cnt<=cnt+1.
//    STABLE_HI / WAIT_LO: mirror image with sync2=0, fall_pulse, level_out<=0;
//      toggle_out unchanged on fall.
//  - Latency: raw_in sampled high at edge E0 and held -> level_out and
//    rise_pulse assert at edge E0+DEBOUNCE_CYCLES+2; pulse deasserts next edge.
//  - Pulses are registered, exactly one cycle wide, never both set on one
//    channel in the same cycle; min spacing between pulses is
//    DEBOUNCE_CYCLES+1 cycles.
//  - cnt saturates by construction (never exceeds DEBOUNCE_CYCLES-1); no wrap.
//  - Channels fully independent: simultaneous changes on several bits are
//    each processed with identical latency.
//  - Reset mid-WAIT: pending change discarded, no pulse emitted.
// STRUCTURE
//  - Shared header input_cond_defs.vh: 2-bit state encodings
//    (STABLE_LO=2'b00, WAIT_HI=2'b01, STABLE_HI=2'b11, WAIT_LO=2'b10) and
//    default DEBOUNCE_CYCLES constant.
//  - Sub-module debounce_channel (1 bit: sync, FSM, counter, pulses, toggle),
//    instantiated WIDTH times via generate in input_conditioner.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, WIDTH=4)
//  1 Reset: rst_n=0 with raw_in=4'hF -> all outputs 0 immediately; hold 10
//    cycles after release -> level_out=4'hF at E0+6, rise_pulse=4'hF 1 cycle.
//  2 Clean press bit0: raw_in 0->1 held -> level_out[0]=1 exactly 6 edges after
//    first sampling edge, rise_pulse[0] high 1 cycle, toggle_out[0]=1.
//  3 Bounce: raw_in[1] high 2 cycles, low 1, high 2, low -> level_out[1],
//    rise_pulse[1] stay 0 throughout.
//  4 Release: from level_out[0]=1, raw_in[0]->0 held -> fall_pulse[0] 1 cycle
//    at +6, level_out[0]=0, toggle_out[0] stays 1; second press -> toggle 0.
//  5 Reset mid-WAIT: raw_in[2] high 3 cycles then rst_n pulse low -> no
//    rise_pulse[2]; after release and 6 more high cycles -> normal rise.
//  6 Simultaneous: raw_in 4'b0000->4'b1010 same cycle -> rise_pulse=4'b1010 in
//    one cycle, other bits untouched.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: debounce state encodings and
// default timing constants.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_WAIT_HI   = 2'b01,
    ST_STABLE_HI = 2'b11,
    ST_WAIT_LO   = 2'b10
  } db_state_e;

  localparam int DEFAULT_WIDTH           = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_W           = 19;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned input bit: 2-flop synchroniser, debounce FSM with stability
// counter, registered level, rise/fall pulses and a press-toggled latch.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic toggle_out
);

  // state        | meaning
  // ST_STABLE_LO | accepted level is 0, watching for a 1
  // ST_WAIT_HI   | input is 1, counting stable cycles before accepting
  // ST_STABLE_HI | accepted level is 1, watching for a 0
  // ST_WAIT_LO   | input is 0, counting stable cycles before accepting

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             toggle_q, toggle_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= ST_STABLE_LO;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync1_q  <= raw_in;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  // The counter only advances while below CNT_LAST, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    case (state_q)
      ST_STABLE_LO: begin
        if (sync2_q) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!sync2_q) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_STABLE_HI;
          level_d  = 1'b1;
          rise_d   = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE_HI: begin
        if (!sync2_q) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (sync2_q) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign toggle_out = toggle_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions WIDTH raw board inputs into debounced levels, edge pulses and
// toggle latches; each channel is an independent debounce_channel.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] toggle_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (raw_in[i]),
      .level_out  (level_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .toggle_out (toggle_out[i])
    );
  end

endmodule
